// File: rtl/lcd_ctrl.sv
// Memory-mapped HD44780-style LCD bus controller: CPU stores queue 10-bit commands
// which are replayed on lcd_data/lcd_en with programmable setup/pulse/hold/exec timing.
module lcd_ctrl #(
    parameter logic [31:0] BASE          = 32'h0000_0040,
    parameter int          FIFO_DEPTH    = 4,
    parameter int          SETUP_CYC     = 2,
    parameter int          PULSE_CYC     = 4,
    parameter int          HOLD_CYC      = 2,
    parameter int          EXEC_CYC      = 40,
    parameter int          LONG_EXEC_CYC = 1600,
    parameter int          CNT_W         = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_wen,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic [1:0]  bus_size,
    output logic [31:0] bus_rdata,
    output logic [9:0]  lcd_data,
    output logic        lcd_en,
    output logic        busy
);
    // state | meaning
    // IDLE  | waiting for a queued command
    // SETUP | lcd_data stable, lcd_en low
    // PULSE | lcd_en high
    // HOLD  | lcd_en low, lcd_data held
    // WAIT  | LCD executing the command
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT} state_t;

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [9:0]       mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             overflow;

    logic       data_wr;
    logic       ctrl_wr;
    logic       flush;
    logic       full;
    logic       empty;
    logic       push;
    logic       pop;
    logic       is_long;
    logic [9:0] push_val;
    logic [2:0] count3;
    logic       unused_bits;

    assign data_wr  = bus_wen && (bus_addr == BASE) && (bus_size != 2'd0);
    assign ctrl_wr  = bus_wen && (bus_addr == BASE + 32'd4) && (bus_size != 2'd0);
    assign flush    = ctrl_wr && bus_wdata[0];
    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    // A full FIFO rejects the push even when the engine pops in the same cycle.
    assign push     = data_wr && !flush && !full;
    assign pop      = (state == S_IDLE) && !empty && !flush;
    assign push_val = (bus_size == 2'd1) ? {2'b10, bus_wdata[7:0]} : bus_wdata[9:0];
    assign is_long  = (lcd_data[9:8] == 2'b00) &&
                      ((lcd_data[7:0] == 8'h01) || (lcd_data[7:0] == 8'h02));

    assign busy      = !empty || (state != S_IDLE);
    assign count3    = (count > CW'(7)) ? 3'd7 : 3'(count);
    assign bus_rdata = (bus_addr == BASE + 32'd4) ?
                       {26'b0, overflow, count3, full, busy} : 32'd0;
    assign unused_bits = ^bus_wdata[31:10];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            if (bus_wdata[1]) begin
                overflow <= 1'b0;
            end
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (data_wr && full) begin
                overflow <= 1'b1;
            end else if (ctrl_wr && bus_wdata[1]) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            lcd_data <= '0;
            lcd_en   <= 1'b0;
        end else if (flush) begin
            state  <= S_IDLE;
            cnt    <= '0;
            lcd_en <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        lcd_data <= mem[rd_ptr];
                        cnt      <= CNT_W'(SETUP_CYC - 1);
                        state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt == '0) begin
                        lcd_en <= 1'b1;
                        cnt    <= CNT_W'(PULSE_CYC - 1);
                        state  <= S_PULSE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_PULSE: begin
                    if (cnt == '0) begin
                        lcd_en <= 1'b0;
                        cnt    <= CNT_W'(HOLD_CYC - 1);
                        state  <= S_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (cnt == '0) begin
                        cnt   <= is_long ? CNT_W'(LONG_EXEC_CYC - 1) : CNT_W'(EXEC_CYC - 1);
                        state <= S_WAIT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_ctrl.sv
// Testbench for lcd_ctrl: decode/format vector table, hand-written timing sequences,
// and randomized bus traffic checked against a timeline-based reference model.
module tb_lcd_ctrl;
    localparam logic [31:0] BASE = 32'h0000_0040;
    localparam logic [31:0] CTRL = 32'h0000_0044;
    localparam int DEPTH = 4, S = 2, P = 4, H = 2, E = 40, L = 1600;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        bus_wen = 1'b0;
    logic [31:0] bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic [1:0]  bus_size = '0;
    logic [31:0] bus_rdata;
    logic [9:0]  lcd_data;
    logic        lcd_en;
    logic        busy;

    int errors = 0;
    int checks = 0;

    lcd_ctrl dut (
        .clk(clk), .reset(reset), .bus_wen(bus_wen), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_size(bus_size), .bus_rdata(bus_rdata),
        .lcd_data(lcd_data), .lcd_en(lcd_en), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: a command queue plus the edge numbers of the current command's phases.
    logic [9:0] q[$];
    bit         m_active = 0;
    int         m_pop = 0, m_done = 0, m_n = 0;
    logic [9:0] m_data = '0;
    bit         m_en = 0, m_ovf = 0;

    task automatic model_step();
        bit flush, clr, dw, cw, prev_active;
        int size_pre;
        logic [9:0] c;
        m_n++;
        if (!reset) begin
            q.delete(); m_active = 0; m_data = '0; m_en = 0; m_ovf = 0;
            return;
        end
        dw = bus_wen && bus_size != 0 && bus_addr == BASE;
        cw = bus_wen && bus_size != 0 && bus_addr == CTRL;
        flush = cw && bus_wdata[0];
        clr = cw && bus_wdata[1];
        if (flush) begin
            q.delete(); m_active = 0; m_en = 0;
            if (clr) m_ovf = 0;
            return;
        end
        prev_active = m_active;
        size_pre = q.size();
        if (m_active && m_n == m_done) m_active = 0;
        if (!prev_active && size_pre > 0) begin
            c = q.pop_front();
            m_data = c;
            m_pop = m_n;
            m_done = m_n + S + P + H +
                     ((c[9:8] == 2'b00 && (c[7:0] == 8'h01 || c[7:0] == 8'h02)) ? L : E);
            m_active = 1;
        end
        if (dw) begin
            if (size_pre < DEPTH)
                q.push_back(bus_size == 2'd1 ? {2'b10, bus_wdata[7:0]} : bus_wdata[9:0]);
            else
                m_ovf = 1;
        end
        if (clr) m_ovf = 0;
        m_en = m_active && (m_n >= m_pop + S) && (m_n < m_pop + S + P);
    endtask

    function automatic logic [31:0] m_status();
        int c;
        bit b;
        c = q.size();
        b = m_active || (c > 0);
        return {26'b0, m_ovf, 3'(c > 7 ? 7 : c), (c == DEPTH), b};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_bus();
        bus_wen = 0; bus_addr = '0; bus_wdata = '0; bus_size = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        bus_wen = 1; bus_addr = a; bus_wdata = d; bus_size = sz;
        tick();
        idle_bus();
    endtask

    task automatic do_reset();
        reset = 0;
        idle_bus();
        repeat (3) tick();
        reset = 1;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic [9:0]  exp_data;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int n, bad;
        vecs[0] = '{BASE,          32'h0000_0238, 2'd3, 10'h238, 1'b1};
        vecs[1] = '{BASE,          32'hFFFF_F3A5, 2'd2, 10'h3A5, 1'b1};
        vecs[2] = '{BASE,          32'h0000_0041, 2'd1, 10'h241, 1'b1};
        vecs[3] = '{BASE,          32'h0000_03FF, 2'd1, 10'h2FF, 1'b1};
        vecs[4] = '{BASE,          32'h0000_0155, 2'd0, 10'h000, 1'b0};
        vecs[5] = '{BASE + 32'd1,  32'h0000_0155, 2'd3, 10'h000, 1'b0};
        vecs[6] = '{BASE + 32'd8,  32'h0000_0155, 2'd3, 10'h000, 1'b0};
        vecs[7] = '{32'h0000_1040, 32'h0000_0155, 2'd3, 10'h000, 1'b0};
        vecs[8] = '{CTRL,          32'h0000_0000, 2'd3, 10'h000, 1'b0};

        // Reset state
        do_reset();
        check("reset lcd_data", 32'(lcd_data), 0);
        check("reset lcd_en", 32'(lcd_en), 0);
        check("reset busy", 32'(busy), 0);
        bus_addr = CTRL; #1;
        check("reset status", bus_rdata, 0);
        idle_bus();

        // Decode and formatting table
        foreach (vecs[i]) begin
            do_reset();
            store(vecs[i].addr, vecs[i].wdata, vecs[i].size);
            tick();
            check($sformatf("vec%0d lcd_data", i), 32'(lcd_data), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
        end

        // Single command timing: store at edge E
        do_reset();
        store(BASE, 32'h238, 2'd3);
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (k == 1) check("t2 lcd_data", 32'(lcd_data), 32'h238);
            check($sformatf("t2 en k=%0d", k), 32'(lcd_en), 32'(k >= 3 && k <= 6));
            check($sformatf("t2 busy k=%0d", k), 32'(busy), 32'(k < 49));
        end

        // Byte store, then long-exec command spacing
        do_reset();
        store(BASE, 32'h41, 2'd1);
        tick();
        check("t3 byte data", 32'(lcd_data), 32'h241);
        n = 0;
        while (busy && n < 200) begin tick(); n++; end
        check("t3 idle wait", 32'(busy), 0);
        store(BASE, 32'h001, 2'd3);
        store(BASE, 32'h238, 2'd3);
        check("t3 clear popped", 32'(lcd_data), 32'h001);
        n = 0;
        while (lcd_data != 10'h238 && n < 3000) begin tick(); n++; end
        check("t3 long period", n, 1609);

        // Overflow
        do_reset();
        for (int i = 0; i < 6; i++) store(BASE, 32'h100 + i, 2'd3);
        bus_addr = CTRL; #1;
        check("t4 status full", bus_rdata, 32'h33);
        check("t4 first popped", 32'(lcd_data), 32'h100);
        store(CTRL, 32'h2, 2'd3);
        bus_addr = CTRL; #1;
        check("t4 ovf cleared", bus_rdata, 32'h13);
        idle_bus();

        // Flush during PULSE
        do_reset();
        store(BASE, 32'h111, 2'd3);
        store(BASE, 32'h122, 2'd3);
        store(BASE, 32'h133, 2'd3);
        n = 0;
        while (!lcd_en && n < 20) begin tick(); n++; end
        check("t5 reach pulse", 32'(lcd_en), 1);
        store(CTRL, 32'h1, 2'd3);
        check("t5 en", 32'(lcd_en), 0);
        check("t5 busy", 32'(busy), 0);
        check("t5 data held", 32'(lcd_data), 32'h111);
        bus_addr = CTRL; #1;
        check("t5 status", bus_rdata, 0);
        idle_bus();
        bad = 0;
        repeat (60) begin tick(); if (lcd_en || busy) bad++; end
        check("t5 quiet after flush", bad, 0);

        // Reset during WAIT with commands queued
        do_reset();
        store(BASE, 32'h151, 2'd3);
        store(BASE, 32'h162, 2'd3);
        store(BASE, 32'h173, 2'd3);
        repeat (20) tick();
        check("t6 busy before reset", 32'(busy), 1);
        reset = 0;
        tick();
        check("t6 lcd_data", 32'(lcd_data), 0);
        check("t6 en", 32'(lcd_en), 0);
        check("t6 busy", 32'(busy), 0);
        bus_addr = CTRL; #1;
        check("t6 status", bus_rdata, 0);
        reset = 1;
        idle_bus();
        bad = 0;
        repeat (100) begin tick(); if (lcd_en || busy || lcd_data != 0) bad++; end
        check("t6 quiet after reset", bad, 0);

        // Randomized traffic against the reference model
        do_reset();
        for (int it = 0; it < 4000; it++) begin
            int r;
            r = $urandom_range(0, 99);
            idle_bus();
            if (r < 25) begin
                bus_wen = 1; bus_addr = BASE; bus_size = 2'($urandom_range(0, 3));
                bus_wdata = $urandom;
                if ($urandom_range(0, 31) == 0) bus_wdata[9:0] = 10'($urandom_range(1, 2));
            end else if (r < 30) begin
                bus_wen = 1; bus_addr = CTRL; bus_size = 2'($urandom_range(1, 3));
                bus_wdata = {30'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0)};
            end else if (r < 35) begin
                bus_wen = 1; bus_size = 2'($urandom_range(1, 3)); bus_wdata = $urandom;
                case ($urandom_range(0, 3))
                    0: bus_addr = BASE + 32'd1;
                    1: bus_addr = BASE + 32'd8;
                    2: bus_addr = BASE - 32'd4;
                    default: bus_addr = 32'h8000_0044;
                endcase
            end else if (r < 45) begin
                bus_addr = CTRL;
            end else begin
                bus_addr = $urandom;
            end
            reset = ($urandom_range(0, 999) != 0);
            tick();
            check("rnd lcd_data", 32'(lcd_data), 32'(m_data));
            check("rnd lcd_en", 32'(lcd_en), 32'(m_en));
            check("rnd busy", 32'(busy), 32'(m_active || q.size() > 0));
            check("rnd rdata", bus_rdata, (bus_addr == CTRL) ? m_status() : 32'd0);
        end
        reset = 1;
        idle_bus();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
